vec_batch_ctrl: RTL and testbench

VEC_BATCH_CTRL -- requirements
Module: vec_batch_ctrl

---
 rtl/vec_batch_ctrl.sv | 102 ++++++++++
 tb/tb_vec_batch_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_batch_ctrl.sv
// Batch sequencer for the fingerprint compare engine: streams the reference block,
// then the compare block, to the vector separator, and waits out the downstream pipeline.
module vec_batch_ctrl #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int REF_VEC_NO   = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cfg_Start,
  input  logic [CNT_WIDTH-1:0] cfg_CmpVecNo,
  output logic                 cfg_Busy,
  output logic                 cfg_Done,
  input  logic [BUS_WIDTH-1:0] s_Data,
  input  logic                 s_Valid,
  output logic                 s_Ready,
  output logic [BUS_WIDTH-1:0] m_Data,
  output logic                 m_Valid,
  output logic                 m_Last,
  input  logic                 m_Ready,
  output logic                 m_RefPhase
);

  localparam int CALC_W    = CNT_WIDTH + $clog2(VECTOR_WIDTH);
  localparam int REF_WORDS = (REF_VEC_NO * VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int DRAIN_W   = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CALC, REF, CMP, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cmp_vec_no;
  logic [CALC_W-1:0]    cmp_words;
  logic [CALC_W-1:0]    word_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [CALC_W:0]      cmp_bits;
  logic                 busy_q, done_q, ref_phase_q;
  logic                 in_stream, xfer, last_word;

  assign in_stream = (state == REF) || (state == CMP);
  assign m_Data    = s_Data;
  assign m_Valid   = in_stream && s_Valid;
  assign s_Ready   = in_stream && m_Ready;
  assign xfer      = m_Valid && m_Ready;
  assign last_word = (state == REF) ? (word_cnt == CALC_W'(REF_WORDS - 1))
                                    : (word_cnt == cmp_words - CALC_W'(1));
  assign m_Last    = m_Valid && last_word;

  // One extra bit keeps the rounding term from overflowing the product width.
  assign cmp_bits = (CALC_W+1)'(cmp_vec_no) * (CALC_W+1)'(VECTOR_WIDTH)
                  + (CALC_W+1)'(BUS_WIDTH - 1);

  assign cfg_Busy   = busy_q;
  assign cfg_Done   = done_q;
  assign m_RefPhase = ref_phase_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cfg_Start) state_nxt = CALC;
      CALC:  state_nxt = REF;
      REF:   if (xfer && last_word) state_nxt = (cmp_words == '0) ? DRAIN : CMP;
      CMP:   if (xfer && last_word) state_nxt = DRAIN;
      DRAIN: if (m_Ready && drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cmp_vec_no  <= '0;
      cmp_words   <= '0;
      word_cnt    <= '0;
      drain_cnt   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ref_phase_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy_q      <= (state_nxt != IDLE);
      done_q      <= (state_nxt == DONE);
      ref_phase_q <= (state_nxt == CALC) || (state_nxt == REF);
      if (state == IDLE && cfg_Start)
        cmp_vec_no <= cfg_CmpVecNo;
      if (state == CALC)
        cmp_words <= CALC_W'(cmp_bits / (CALC_W+1)'(BUS_WIDTH));
      if (state_nxt != state)
        word_cnt <= '0;
      else if (xfer)
        word_cnt <= word_cnt + CALC_W'(1);
      if (state != DRAIN)
        drain_cnt <= '0;
      else if (m_Ready)
        drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

endmodule

// File: tb/tb_vec_batch_ctrl.sv
// Directed bench for vec_batch_ctrl: drives batches from a counting source and checks
// phase word totals, m_Last placement, completion timing and reset behaviour.
module tb_vec_batch_ctrl;

  localparam int BUS_WIDTH = 128;
  localparam int CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 cfg_Start = 1'b0;
  logic [CNT_WIDTH-1:0] cfg_CmpVecNo = '0;
  logic                 cfg_Busy, cfg_Done;
  logic [BUS_WIDTH-1:0] s_Data = '0;
  logic                 s_Valid = 1'b0;
  logic                 s_Ready;
  logic [BUS_WIDTH-1:0] m_Data;
  logic                 m_Valid, m_Last;
  logic                 m_Ready = 1'b0;
  logic                 m_RefPhase;

  int errors = 0;
  int checks = 0;

  int ref_cnt, cmp_cnt, ref_last, cmp_last, last_cnt, last_err, data_err;
  int done_cnt, done_delay, done_cyc, last_xfer_cyc, src_idx;
  int gap_xfer, stall_last_seen;
  logic busy_at1, refph_at1, busy_after;

  vec_batch_ctrl dut (
    .clk(clk), .rstn(rstn),
    .cfg_Start(cfg_Start), .cfg_CmpVecNo(cfg_CmpVecNo),
    .cfg_Busy(cfg_Busy), .cfg_Done(cfg_Done),
    .s_Data(s_Data), .s_Valid(s_Valid), .s_Ready(s_Ready),
    .m_Data(m_Data), .m_Valid(m_Valid), .m_Last(m_Last),
    .m_Ready(m_Ready), .m_RefPhase(m_RefPhase)
  );

  always #5 clk = ~clk;

  function automatic logic [BUS_WIDTH-1:0] pat(input int i);
    return {4{32'(i) ^ 32'h5A5A_0000}};
  endfunction

  // Runs one batch from a counting source; inputs change on the falling edge and
  // outputs are sampled 1 time unit later. reset_at >= 0 aborts with rstn=0 at that REF word.
  task automatic drive_batch(input int cmp_no, input bit toggle_rdy, input bit spur_start,
                             input bit gap, input int reset_at);
    int  gap_left = 0;
    bit  spur_done = 0, gap_done = 0, prev_stall_last = 0;
    ref_cnt = 0; cmp_cnt = 0; ref_last = -1; cmp_last = -1; last_cnt = 0; last_err = 0;
    data_err = 0; done_cnt = 0; done_delay = -1; done_cyc = -100; last_xfer_cyc = 0;
    src_idx = 0; gap_xfer = 0; stall_last_seen = 0; busy_at1 = 0; refph_at1 = 0; busy_after = 1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (reset_at >= 0 && ref_cnt == reset_at) begin
        rstn = 1'b0;
        cfg_Start = 1'b0;
        return;
      end
      cfg_Start    = (cyc == 0);
      cfg_CmpVecNo = CNT_WIDTH'(cmp_no);
      if (spur_start && !spur_done && cmp_cnt == 3) begin
        cfg_Start = 1'b1; cfg_CmpVecNo = 16'd9; spur_done = 1;
      end
      if (gap && !gap_done && cmp_cnt == 5) begin
        gap_left = 5; gap_done = 1;
      end
      s_Valid = (gap_left == 0);
      m_Ready = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
      s_Data  = pat(src_idx);
      #1;
      if (gap_left > 0) begin
        if (m_Valid) gap_xfer++;
        gap_left--;
      end
      if (m_Last && !m_Valid) last_err++;
      if (prev_stall_last && !m_Last) last_err++;
      prev_stall_last = m_Valid && m_Last && !m_Ready;
      if (prev_stall_last) stall_last_seen++;
      if (cyc == 1) begin busy_at1 = cfg_Busy; refph_at1 = m_RefPhase; end
      if (m_Valid && m_Ready) begin
        if (m_Data !== pat(src_idx)) data_err++;
        if (m_RefPhase) begin
          if (m_Last) begin ref_last = ref_cnt; last_cnt++; end
          ref_cnt++;
        end else begin
          if (m_Last) begin cmp_last = cmp_cnt; last_cnt++; end
          cmp_cnt++;
        end
        src_idx++;
        last_xfer_cyc = cyc;
      end
      if (cfg_Done) begin
        done_cnt++;
        if (done_cnt == 1) begin done_delay = cyc - last_xfer_cyc; done_cyc = cyc; end
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) busy_after = cfg_Busy;
      if (done_cnt > 0 && cyc >= done_cyc + 6) break;
    end
    cfg_Start = 1'b0;
    s_Valid   = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_Valid = 1'b1; m_Ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks += 6;
    if (cfg_Busy   !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", cfg_Busy); end
    if (cfg_Done   !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", cfg_Done); end
    if (s_Ready    !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_Ready); end
    if (m_Valid    !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_Valid); end
    if (m_Last     !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last: got %b expected 0", m_Last); end
    if (m_RefPhase !== 1'b0) begin errors++; $display("[TB] FAIL reset_refphase: got %b expected 0", m_RefPhase); end
    s_Valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_nominal();
    drive_batch(2, 0, 0, 0, -1);
    checks += 11;
    if (ref_cnt != 29)   begin errors++; $display("[TB] FAIL nom_ref_words: got %0d expected 29", ref_cnt); end
    if (cmp_cnt != 15)   begin errors++; $display("[TB] FAIL nom_cmp_words: got %0d expected 15", cmp_cnt); end
    if (ref_last != 28)  begin errors++; $display("[TB] FAIL nom_ref_last: got %0d expected 28", ref_last); end
    if (cmp_last != 14)  begin errors++; $display("[TB] FAIL nom_cmp_last: got %0d expected 14", cmp_last); end
    if (last_cnt != 2)   begin errors++; $display("[TB] FAIL nom_last_count: got %0d expected 2", last_cnt); end
    if (last_err != 0)   begin errors++; $display("[TB] FAIL nom_last_qual: got %0d expected 0", last_err); end
    if (done_cnt != 1)   begin errors++; $display("[TB] FAIL nom_done_count: got %0d expected 1", done_cnt); end
    if (done_delay != 4) begin errors++; $display("[TB] FAIL nom_done_delay: got %0d expected 4", done_delay); end
    if (busy_at1 !== 1'b1)   begin errors++; $display("[TB] FAIL nom_busy_calc: got %b expected 1", busy_at1); end
    if (refph_at1 !== 1'b1)  begin errors++; $display("[TB] FAIL nom_refphase_calc: got %b expected 1", refph_at1); end
    if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL nom_busy_after: got %b expected 0", busy_after); end
  endtask

  task automatic test_backpressure();
    drive_batch(2, 1, 0, 0, -1);
    checks += 7;
    if (ref_cnt != 29)  begin errors++; $display("[TB] FAIL bp_ref_words: got %0d expected 29", ref_cnt); end
    if (cmp_cnt != 15)  begin errors++; $display("[TB] FAIL bp_cmp_words: got %0d expected 15", cmp_cnt); end
    if (data_err != 0)  begin errors++; $display("[TB] FAIL bp_data_order: got %0d bad words expected 0", data_err); end
    if (ref_last != 28 || cmp_last != 14)
      begin errors++; $display("[TB] FAIL bp_last_index: got %0d/%0d expected 28/14", ref_last, cmp_last); end
    if (last_err != 0)  begin errors++; $display("[TB] FAIL bp_last_held: got %0d drops expected 0", last_err); end
    if (stall_last_seen < 1) begin errors++; $display("[TB] FAIL bp_last_stalled: got %0d expected >=1", stall_last_seen); end
    if (done_cnt != 1)  begin errors++; $display("[TB] FAIL bp_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_empty_cmp();
    drive_batch(0, 0, 0, 0, -1);
    checks += 5;
    if (ref_cnt != 29)   begin errors++; $display("[TB] FAIL empty_ref_words: got %0d expected 29", ref_cnt); end
    if (cmp_cnt != 0)    begin errors++; $display("[TB] FAIL empty_cmp_words: got %0d expected 0", cmp_cnt); end
    if (ref_last != 28)  begin errors++; $display("[TB] FAIL empty_ref_last: got %0d expected 28", ref_last); end
    if (done_cnt != 1)   begin errors++; $display("[TB] FAIL empty_done_count: got %0d expected 1", done_cnt); end
    if (done_delay != 4) begin errors++; $display("[TB] FAIL empty_done_delay: got %0d expected 4", done_delay); end
  endtask

  task automatic test_ignored_start();
    drive_batch(2, 0, 1, 0, -1);
    checks += 3;
    if (cmp_cnt != 15)  begin errors++; $display("[TB] FAIL spur_cmp_words: got %0d expected 15", cmp_cnt); end
    if (cmp_last != 14) begin errors++; $display("[TB] FAIL spur_cmp_last: got %0d expected 14", cmp_last); end
    if (done_cnt != 1)  begin errors++; $display("[TB] FAIL spur_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_batch();
    drive_batch(2, 0, 0, 0, 10);
    @(negedge clk);
    #1;
    checks += 4;
    if (cfg_Busy !== 1'b0)   begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", cfg_Busy); end
    if (s_Ready !== 1'b0)    begin errors++; $display("[TB] FAIL midrst_s_ready: got %b expected 0", s_Ready); end
    if (m_Valid !== 1'b0 || m_Last !== 1'b0)
      begin errors++; $display("[TB] FAIL midrst_m_valid_last: got %b%b expected 00", m_Valid, m_Last); end
    if (m_RefPhase !== 1'b0) begin errors++; $display("[TB] FAIL midrst_refphase: got %b expected 0", m_RefPhase); end
    rstn = 1'b1;
    drive_batch(2, 0, 0, 0, -1);
    checks += 3;
    if (ref_cnt != 29) begin errors++; $display("[TB] FAIL midrst_new_ref_words: got %0d expected 29", ref_cnt); end
    if (cmp_cnt != 15) begin errors++; $display("[TB] FAIL midrst_new_cmp_words: got %0d expected 15", cmp_cnt); end
    if (done_cnt != 1) begin errors++; $display("[TB] FAIL midrst_new_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_source_gaps();
    drive_batch(2, 0, 0, 1, -1);
    checks += 5;
    if (gap_xfer != 0)  begin errors++; $display("[TB] FAIL gap_valid_leak: got %0d expected 0", gap_xfer); end
    if (ref_cnt != 29)  begin errors++; $display("[TB] FAIL gap_ref_words: got %0d expected 29", ref_cnt); end
    if (cmp_cnt != 15)  begin errors++; $display("[TB] FAIL gap_cmp_words: got %0d expected 15", cmp_cnt); end
    if (cmp_last != 14) begin errors++; $display("[TB] FAIL gap_cmp_last: got %0d expected 14", cmp_last); end
    if (done_cnt != 1)  begin errors++; $display("[TB] FAIL gap_done_count: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_empty_cmp();
    test_ignored_start();
    test_reset_mid_batch();
    test_source_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
